bit_message_printer: RTL and testbench
======================================

Name: bit_message_printer

Overview:
- Parametrised successor to the UART message printer.
- Collects WORD_W ASCII '0'/'1' characters from the UART receiver, MSB first, into a word.
- Then sends a fixed ROM message, the word echoed in binary or hex, and CR LF, all through the UART transmitter handshake.
- Sits between uart_rx/uart_tx and is the only user of both in the top level.

Parameters:
- WORD_W, 8: number of bits collected per word; 1..32.
- MSG_LEN, 16: number of ROM message bytes. Default content is "Value received: ".
- MODE, 1: echo format. 0 = binary, WORD_W chars '0'/'1'. 1 = hex, ceil(WORD_W/4) uppercase digits.
- AW, $clog2(MSG_LEN): width of the ROM address.
- CW, $clog2(WORD_W+1): width of the bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- tx_data  out  8  byte to the transmitter; valid while new_tx_data=1.
- new_tx_data  out  1  one-cycle strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- new_rx_data  in  1  one-cycle strobe; rx_data valid in that cycle.
- rx_data  in  8  received byte.
- addr  out  AW  current ROM address.
- counter  out  CW  number of bits collected so far.
- busy  out  1  high in any state other than COLLECT.
- rx_err  out  1  one-cycle pulse: a byte other than '0'/'1' arrived in COLLECT.
- rx_drop  out  1  one-cycle pulse: any byte arrived outside COLLECT.

Behaviour:
- Reset (rst=0 at a clk edge), values visible the next cycle:
  - state=COLLECT.
  - tx_data=0, new_tx_data=0, addr=0, counter=0, word=0, busy=0, rx_err=0, rx_drop=0, wait flag=0.
  - Reset overrides everything, including a print in progress. Any partly sent message is abandoned.
- State machine: COLLECT -> MSG -> WORD -> CRLF -> COLLECT.
- COLLECT:
  - new_rx_data with '1' (0x31) or '0' (0x30): word <= {word[WORD_W-2:0], bit}; counter += 1.
  - When counter reaches WORD_W on that edge, the next state is MSG and counter resets to 0.
  - Any other byte: word and counter unchanged; rx_err pulses for one cycle.
- Send rule, common to MSG, WORD and CRLF:
  - A byte is issued in a cycle where tx_busy=0 and the wait flag is 0.
  - Issuing a byte means: tx_data=byte, new_tx_data=1 for exactly that cycle, wait flag set.
  - The wait flag clears the following cycle. Two strobes are therefore never adjacent, which gives the transmitter one cycle to raise tx_busy.
  - While tx_busy=1, nothing is issued and all state holds. There is no timeout.
- MSG: sends ROM[addr] for addr = 0..MSG_LEN-1. After the last byte is issued, addr returns to 0 and the state goes to WORD.
- WORD:
  - MODE=0: sends word bits MSB first as '0'/'1'.
  - MODE=1: sends nibbles MSB first. The top nibble is zero-padded when WORD_W%4 != 0.
  - Digit encoding: n<10 -> 0x30+n; otherwise 0x41+n-10.
  - An internal index counts the characters. After the last character, the state goes to CRLF.
- CRLF: sends 0x0D then 0x0A, then goes to COLLECT and clears word to 0.
- Latency: the first new_tx_data is asserted no earlier than the cycle after the edge that stored the final bit, and only if tx_busy=0 then.
- new_rx_data outside COLLECT: the byte is discarded, rx_drop pulses, and the word is untouched.
- A strobe during the cycle that leaves CRLF is still discarded (the state is not yet COLLECT).
- new_rx_data and new_tx_data in the same cycle are legal. The receive and transmit paths are independent.
- Total bytes sent per word: MSG_LEN + (MODE ? ceil(WORD_W/4) : WORD_W) + 2.

Decomposition:
- Package bit_msg_pkg:
  - State enum: COLLECT, MSG, WORD, CRLF.
  - ASCII constants: ASC_0=0x30, ASC_1=0x31, ASC_A=0x41, ASC_CR=0x0D, ASC_LF=0x0A.
  - Function nibble_to_ascii.
- Sub-module bit_message_rom:
  - Combinational or registered read; addr in, 8-bit data out.
  - Parameter MSG_LEN; content set by a case statement.
  - If the read is registered, the top module accounts for the one-cycle read latency before issuing.

Test Plan:
1. Default parameters; send "11110000", one strobe every 100 cycles; tx_busy held 0 -> 20 strobes: "Value received: F0\r\n". Strobes spaced at least 2 cycles apart; counter returns 0; busy falls after 0x0A.
2. MODE=0, WORD_W=4; send "1010" -> "Value received: 1010\r\n" (22 bytes).
3. Send "1x1" -> rx_err pulses once on 'x'; counter goes 1 -> 1 -> 2; no transmission starts.
4. During MSG, hold tx_busy=1 for 50 cycles after the 3rd byte -> no strobe during the hold; the 4th byte 'u' is issued once tx_busy drops; sequence otherwise unchanged.
5. Send byte '1' while busy=1 -> rx_drop pulses once; the echoed word is unchanged; counter stays 0 afterwards.
6. Drive rst=0 for one edge at addr=5 in MSG -> next cycle: all outputs 0, state COLLECT. A following "00000001" yields "Value received: 01\r\n".

Source files
------------

// File: rtl/bit_msg_pkg.sv
// bit_msg_pkg: shared state encoding, ASCII constants and digit helper for the bit message printer.
// Revision 1.0
`default_nettype none

package bit_msg_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MSG     = 2'd1,
    WORD    = 2'd2,
    CRLF    = 2'd3
  } state_t;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASC_0 + {4'h0, n};
    end
    return ASC_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_message_rom.sv
// bit_message_rom: combinational message ROM, "Value received: " followed by spaces.
// Revision 1.0
`default_nettype none

module bit_message_rom #(
  parameter int MSG_LEN = 16,
  parameter int AW      = $clog2(MSG_LEN)
) (
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);

  always_comb begin
    data = 8'h20;
    if (int'(addr) < MSG_LEN) begin
      case (int'(addr))
        0:       data = "V";
        1:       data = "a";
        2:       data = "l";
        3:       data = "u";
        4:       data = "e";
        5:       data = " ";
        6:       data = "r";
        7:       data = "e";
        8:       data = "c";
        9:       data = "e";
        10:      data = "i";
        11:      data = "v";
        12:      data = "e";
        13:      data = "d";
        14:      data = ":";
        15:      data = " ";
        default: data = 8'h20;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit_message_printer.sv
// bit_message_printer: collects ASCII '0'/'1' bits into a word, then prints message, word and CR LF.
// Revision 1.0
`default_nettype none

module bit_message_printer
  import bit_msg_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int MSG_LEN = 16,
  parameter int MODE    = 1,
  parameter int AW      = $clog2(MSG_LEN),
  parameter int CW      = $clog2(WORD_W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  input  logic          new_rx_data,
  input  logic [7:0]    rx_data,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] counter,
  output logic          busy,
  output logic          rx_err,
  output logic          rx_drop
);

  localparam int NCHAR = (MODE != 0) ? (WORD_W + 3) / 4 : WORD_W;
  localparam int IW    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int PW    = ((WORD_W + 3) / 4) * 4;

  state_t              state_q, state_d;
  logic [7:0]          tx_data_d;
  logic                new_tx_d;
  logic [AW-1:0]       addr_d;
  logic [CW-1:0]       counter_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                rx_err_d, rx_drop_d;
  logic                wait_q, wait_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                lf_q, lf_d;

  logic [7:0]          rom_data;
  logic [7:0]          word_char;
  logic [7:0]          cur_byte;
  logic [WORD_W-1:0]   shift_in;
  logic [IW-1:0]       pos;
  logic                can_send;
  logic                rx_is_bit;

  bit_message_rom #(
    .MSG_LEN(MSG_LEN),
    .AW     (AW)
  ) u_rom (
    .addr(addr),
    .data(rom_data)
  );

  generate
    if (WORD_W > 1) begin : g_shift_wide
      assign shift_in = {word_q[WORD_W-2:0], rx_data[0]};
    end else begin : g_shift_one
      assign shift_in = rx_data[0];
    end
  endgenerate

  // pos counts down from the most significant character as idx counts up
  assign pos = IW'(NCHAR - 1) - idx_q;

  generate
    if (MODE != 0) begin : g_hex
      logic [PW-1:0] padded;
      assign padded    = PW'(word_q);
      assign word_char = nibble_to_ascii(padded[{pos, 2'b00} +: 4]);
    end else begin : g_bin
      assign word_char = word_q[pos] ? ASC_1 : ASC_0;
    end
  endgenerate

  assign busy      = (state_q != COLLECT);
  assign can_send  = !tx_busy && !wait_q;
  assign rx_is_bit = (rx_data == ASC_0) || (rx_data == ASC_1);

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data;
    new_tx_d  = 1'b0;
    addr_d    = addr;
    counter_d = counter;
    word_d    = word_q;
    rx_err_d  = 1'b0;
    rx_drop_d = 1'b0;
    wait_d    = 1'b0;
    idx_d     = idx_q;
    lf_d      = lf_q;

    case (state_q)
      MSG:     cur_byte = rom_data;
      WORD:    cur_byte = word_char;
      CRLF:    cur_byte = lf_q ? ASC_LF : ASC_CR;
      default: cur_byte = 8'h00;
    endcase

    if (state_q == COLLECT) begin
      if (new_rx_data) begin
        if (rx_is_bit) begin
          word_d = shift_in;
          if (counter == CW'(WORD_W - 1)) begin
            counter_d = '0;
            state_d   = MSG;
          end else begin
            counter_d = counter + 1'b1;
          end
        end else begin
          rx_err_d = 1'b1;
        end
      end
    end else begin
      rx_drop_d = new_rx_data;
      if (can_send) begin
        tx_data_d = cur_byte;
        new_tx_d  = 1'b1;
        wait_d    = 1'b1;
        case (state_q)
          MSG: begin
            if (addr == AW'(MSG_LEN - 1)) begin
              addr_d  = '0;
              state_d = WORD;
            end else begin
              addr_d = addr + 1'b1;
            end
          end
          WORD: begin
            if (idx_q == IW'(NCHAR - 1)) begin
              idx_d   = '0;
              state_d = CRLF;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          CRLF: begin
            if (lf_q) begin
              lf_d    = 1'b0;
              word_d  = '0;
              state_d = COLLECT;
            end else begin
              lf_d = 1'b1;
            end
          end
          default: state_d = COLLECT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      addr        <= '0;
      counter     <= '0;
      word_q      <= '0;
      rx_err      <= 1'b0;
      rx_drop     <= 1'b0;
      wait_q      <= 1'b0;
      idx_q       <= '0;
      lf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data     <= tx_data_d;
      new_tx_data <= new_tx_d;
      addr        <= addr_d;
      counter     <= counter_d;
      word_q      <= word_d;
      rx_err      <= rx_err_d;
      rx_drop     <= rx_drop_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      lf_q        <= lf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_message_printer.sv
// tb_bit_message_printer: table, directed and random checks of two printer configurations.
// Revision 1.0
`default_nettype none

module tb_bit_message_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // hex instance (defaults)
  logic [7:0] tx_data0;
  logic       new_tx0;
  logic       tx_busy0;
  logic       new_rx0;
  logic [7:0] rx_data0;
  logic [3:0] addr0;
  logic [3:0] counter0;
  logic       busy0, rx_err0, rx_drop0;
  // binary instance, 4-bit words
  logic [7:0] tx_data1;
  logic       new_tx1;
  logic       tx_busy1;
  logic       new_rx1;
  logic [7:0] rx_data1;
  logic [3:0] addr1;
  logic [2:0] counter1;
  logic       busy1, rx_err1, rx_drop1;

  bit_message_printer dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .new_tx_data(new_tx0), .tx_busy(tx_busy0),
    .new_rx_data(new_rx0), .rx_data(rx_data0), .addr(addr0), .counter(counter0),
    .busy(busy0), .rx_err(rx_err0), .rx_drop(rx_drop0)
  );

  bit_message_printer #(.WORD_W(4), .MODE(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .new_tx_data(new_tx1), .tx_busy(tx_busy1),
    .new_rx_data(new_rx1), .rx_data(rx_data1), .addr(addr1), .counter(counter1),
    .busy(busy1), .rx_err(rx_err1), .rx_drop(rx_drop1)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  bit   tx_model_en = 1'b0;

  typedef struct {
    logic [7:0]  word;
    logic [15:0] hex;
  } vec0_t;

  typedef struct {
    logic [3:0]  word;
    logic [31:0] bin;
  } vec1_t;

  vec0_t tab0[6];
  vec1_t tab1[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Byte monitor, strobe spacing check and a simple transmitter busy model for dut0
  initial begin
    bit prev0 = 1'b0;
    bit prev1 = 1'b0;
    int hold  = 0;
    forever begin
      @(negedge clk);
      if (new_tx0) begin
        q0.push_back(tx_data0);
        tests++;
        if (prev0) begin
          fails++;
          $display("FAIL strobe_gap0: got adjacent strobes, expected at least one idle cycle");
        end
      end
      if (new_tx1) begin
        q1.push_back(tx_data1);
        tests++;
        if (prev1) begin
          fails++;
          $display("FAIL strobe_gap1: got adjacent strobes, expected at least one idle cycle");
        end
      end
      prev0 = new_tx0;
      prev1 = new_tx1;
      if (tx_model_en) begin
        if (new_tx0) begin
          tx_busy0 = 1'b1;
          hold     = int'($urandom_range(1, 4));
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) tx_busy0 = 1'b0;
        end
      end
    end
  end

  task automatic exp_begin();
    string pfx = "Value received: ";
    exp_q.delete();
    for (int i = 0; i < pfx.len(); i++) begin
      logic [7:0] c;
      c = pfx[i];
      exp_q.push_back(c);
    end
  endtask

  task automatic exp_end();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic exp_packed(input logic [63:0] p, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(p[8*i +: 8]);
  endtask

  // Reference formatting straight from the digit rules
  task automatic exp_model(input int unsigned w, input int width, input bit hex);
    if (hex) begin
      for (int i = (width + 3) / 4 - 1; i >= 0; i--) begin
        int unsigned n;
        n = (w >> (4 * i)) & 15;
        exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
      end
    end else begin
      for (int i = width - 1; i >= 0; i--) exp_q.push_back(((w >> i) & 1) != 0 ? 8'h31 : 8'h30);
    end
  endtask

  task automatic check_msg(input string name, input int sel);
    logic [7:0] got[$];
    int diff;
    got  = (sel == 0) ? q0 : q1;
    diff = -1;
    tests++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      if (diff < 0 && got[i] !== exp_q[i]) diff = i;
    end
    if (got.size() != exp_q.size() || diff >= 0) begin
      fails++;
      if (diff < 0) diff = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      $display("FAIL %s: got %0d bytes (byte %0d = %02h), expected %0d bytes (byte %0d = %02h)",
               name, got.size(), diff, (diff < got.size()) ? got[diff] : 8'hxx,
               exp_q.size(), diff, (diff < exp_q.size()) ? exp_q[diff] : 8'hxx);
    end
    if (sel == 0) q0.delete(); else q1.delete();
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin rx_data0 = b; new_rx0 = 1'b1; end
    else          begin rx_data1 = b; new_rx1 = 1'b1; end
    @(negedge clk);
    new_rx0 = 1'b0; new_rx1 = 1'b0;
    rx_data0 = 8'h00; rx_data1 = 8'h00;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int width, input int gap);
    for (int i = width - 1; i >= 0; i--) begin
      send_byte(sel, w[i] ? 8'h31 : 8'h30);
      if (i > 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int sel, input string name);
    int n = 0;
    while (((sel == 0) ? busy0 : busy1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, n < 5000, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int n, cnt, extra;
    logic [31:0] w;

    tab0[0] = '{word: 8'hF0, hex: "F0"};
    tab0[1] = '{word: 8'h01, hex: "01"};
    tab0[2] = '{word: 8'hA5, hex: "A5"};
    tab0[3] = '{word: 8'h00, hex: "00"};
    tab0[4] = '{word: 8'hFF, hex: "FF"};
    tab0[5] = '{word: 8'h3C, hex: "3C"};
    tab1[0] = '{word: 4'hA, bin: "1010"};
    tab1[1] = '{word: 4'h0, bin: "0000"};
    tab1[2] = '{word: 4'hF, bin: "1111"};
    tab1[3] = '{word: 4'h6, bin: "0110"};

    rst = 1'b0;
    tx_busy0 = 1'b0; tx_busy1 = 1'b0;
    new_rx0 = 1'b0; new_rx1 = 1'b0;
    rx_data0 = 8'h00; rx_data1 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("reset_tx_data", tx_data0, 0);
    check("reset_new_tx", new_tx0, 0);
    check("reset_addr", addr0, 0);
    check("reset_counter", counter0, 0);
    check("reset_busy", busy0, 0);
    check("reset_rx_err", rx_err0, 0);
    check("reset_rx_drop", rx_drop0, 0);
    check("reset_busy1", busy1, 0);

    // Table: hex instance, first entry with slow bit spacing and idle transmitter
    for (int t = 0; t < 6; t++) begin
      send_word(0, 32'(tab0[t].word), 8, (t == 0) ? 100 : 1);
      wait_idle(0, "tab0");
      exp_begin(); exp_packed(64'(tab0[t].hex), 2); exp_end();
      check_msg("tab0_msg", 0);
      check("tab0_counter", counter0, 0);
      check("tab0_busy", busy0, 0);
    end

    for (int t = 0; t < 4; t++) begin
      send_word(1, 32'(tab1[t].word), 4, 2);
      wait_idle(1, "tab1");
      exp_begin(); exp_packed(64'(tab1[t].bin), 4); exp_end();
      check_msg("tab1_msg", 1);
      check("tab1_counter", counter1, 0);
    end

    // Invalid character mid-word
    send_byte(0, 8'h31);
    check("err_cnt1", counter0, 1);
    send_byte(0, "x");
    check("err_pulse", rx_err0, 1);
    check("err_cnt_hold", counter0, 1);
    @(negedge clk);
    check("err_pulse_end", rx_err0, 0);
    send_byte(0, 8'h31);
    check("err_cnt2", counter0, 2);
    check("err_no_busy", busy0, 0);
    check("err_no_tx", q0.size(), 0);
    send_word(0, 32'b000101, 6, 1);
    wait_idle(0, "err");
    exp_begin(); exp_packed(64'("C5"), 2); exp_end();
    check_msg("err_msg", 0);

    // Transmitter stalls after the third message byte
    tx_model_en = 1'b0;
    tx_busy0 = 1'b0;
    send_word(0, 32'h5A, 8, 1);
    cnt = 0; n = 0;
    while (cnt < 3 && n < 1000) begin
      @(negedge clk);
      if (new_tx0) cnt++;
      n++;
    end
    check("stall_reach3", cnt, 3);
    tx_busy0 = 1'b1;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (new_tx0) extra++;
    end
    check("stall_no_strobe", extra, 0);
    tx_busy0 = 1'b0;
    wait_idle(0, "stall");
    exp_begin(); exp_packed(64'("5A"), 2); exp_end();
    check_msg("stall_msg", 0);

    // Byte arriving while printing is dropped
    tx_model_en = 1'b1;
    send_word(0, 32'h96, 8, 1);
    send_byte(0, 8'h31);
    check("drop_pulse", rx_drop0, 1);
    check("drop_no_err", rx_err0, 0);
    @(negedge clk);
    check("drop_pulse_end", rx_drop0, 0);
    wait_idle(0, "drop");
    exp_begin(); exp_packed(64'("96"), 2); exp_end();
    check_msg("drop_msg", 0);
    check("drop_counter", counter0, 0);

    // Reset in the middle of the message
    send_word(0, 32'h77, 8, 1);
    n = 0;
    while (addr0 != 4'd5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_addr5", addr0, 5);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_tx_data", tx_data0, 0);
    check("rst_new_tx", new_tx0, 0);
    check("rst_addr", addr0, 0);
    check("rst_counter", counter0, 0);
    check("rst_busy", busy0, 0);
    check("rst_rx_err", rx_err0, 0);
    check("rst_rx_drop", rx_drop0, 0);
    q0.delete();
    q1.delete();
    send_word(0, 32'h01, 8, 1);
    wait_idle(0, "rst");
    exp_begin(); exp_packed(64'("01"), 2); exp_end();
    check_msg("rst_msg", 0);

    // Random words against the reference formatter
    for (int r = 0; r < 8; r++) begin
      w = 32'($urandom_range(0, 255));
      send_word(0, w, 8, int'($urandom_range(0, 3)));
      wait_idle(0, "rand0");
      exp_begin(); exp_model(w, 8, 1'b1); exp_end();
      check_msg("rand0_msg", 0);
      check("rand0_counter", counter0, 0);
    end
    for (int r = 0; r < 4; r++) begin
      w = 32'($urandom_range(0, 15));
      send_word(1, w, 4, int'($urandom_range(0, 3)));
      wait_idle(1, "rand1");
      exp_begin(); exp_model(w, 4, 1'b0); exp_end();
      check_msg("rand1_msg", 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
